revaluate_stream: RTL and testbench

- Chi (revaluate) step of the Keccak-f[1600] round, placed directly downstream of the permute (pi) stage.
- Consumes the 64 permuted 25-bit slices, one per handshake, and applies chi row-wise within each slice.
- Emits each result with its slice index to the next round stage (iota/add-RC).
- A start/finish controller frames one full 64-slice state per run.

---
 rtl/revaluate_stream_if.sv | 32 +++
 rtl/revaluate_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_revaluate_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/revaluate_stream_if.sv
// Slice stream interface for the Keccak chi (revaluate) stage.
// Carries the permuted-slice input handshake and the chi-result output
// handshake (with slice index) between pi, chi and the iota stage.
//   in_slice    : permuted 25-bit slice, bit index 5*y+x
//   in_valid    : in_slice valid
//   in_ready    : chi stage accepts in_slice
//   out_slice   : chi result, same bit layout
//   out_valid   : out_slice/slice_index valid
//   out_ready   : downstream accepts the result
//   slice_index : z index of out_slice
// Modports: master = environment/upstream+downstream side, slave = chi stage.
interface revaluate_stream_if #(
  parameter int unsigned IDX_W = 6
) ();
  logic [24:0]      in_slice;
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      out_slice;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] slice_index;

  modport master (
    output in_slice, in_valid, out_ready,
    input  in_ready, out_slice, out_valid, slice_index
  );

  modport slave (
    input  in_slice, in_valid, out_ready,
    output in_ready, out_slice, out_valid, slice_index
  );
endinterface

// File: rtl/revaluate_stream.sv
// Keccak-f[1600] chi (revaluate) stage, slice-serial.
// Accepts the 64 permuted 25-bit slices of one state, applies chi row-wise
// inside each slice and emits each result tagged with its slice index.
// A start/finish controller frames one full state per run.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   start  : one-cycle request to process a state (honoured only in IDLE)
//   busy   : controller is in RUN
//   finish : one-cycle pulse after the last slice has left
//   strm   : slice stream interface (slave modport)
// Build option REVALUATE_SKID_EN: 2-entry output buffer with a registered
// in_ready (no out_ready -> in_ready combinational path). Without it a single
// output register is used and in_ready depends combinationally on out_ready.
module revaluate_stream #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                finish,
  revaluate_stream_if.slave   strm
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(SLICES);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(SLICES - 1);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  state_t         state_q;
  logic [IDX_W:0] in_cnt_q;
  logic [IDX_W:0] in_cnt_d;
  logic [IDX_W:0] out_cnt_q;
  logic           busy_q;
  logic           finish_q;

  logic           in_fire;
  logic           out_fire;
  logic           last_out;
  logic [24:0]    chi_res;

  // chi within each 5-bit row; x indices wrap inside the row only
  function automatic logic [24:0] chi(input logic [24:0] a);
    logic [24:0] r;
    r = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
      end
    end
    return r;
  endfunction

  assign chi_res  = chi(strm.in_slice);
  assign in_fire  = strm.in_valid & strm.in_ready;
  assign out_fire = strm.out_valid & strm.out_ready;
  assign last_out = out_fire && (out_cnt_q == CNT_LAST);

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (state_q == IDLE && start) begin
      in_cnt_d = '0;
    end else if (in_fire) begin
      in_cnt_d = in_cnt_q + CNT_ONE;
    end
  end

  // Controller: single registered FSM with registered busy/finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            out_cnt_q <= '0;
          end
        end
        RUN: begin
          if (out_fire) begin
            out_cnt_q <= out_cnt_q + CNT_ONE;
          end
          if (last_out) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          finish_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign finish = finish_q;

`ifdef REVALUATE_SKID_EN
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic [24:0]      d0_q;
  logic [24:0]      d1_q;
  logic [IDX_W-1:0] t0_q;
  logic [IDX_W-1:0] t1_q;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             run_d;

  // in_ready is precomputed from the post-edge occupancy, counter and state
  // so the upstream side never sees out_ready combinationally.
  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + 2'd1;
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - 2'd1;
    end
    run_d      = (state_q == IDLE && start) || (state_q == RUN && !last_out);
    in_ready_d = run_d && (in_cnt_d < CNT_FULL) && (occ_d < 2'd2);
  end

  // d0 is always the head (visible) entry; d1 holds the second entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      in_ready_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      case ({in_fire, out_fire})
        2'b10: begin
          if (occ_q == 2'd0) begin
            d0_q <= chi_res;
            t0_q <= in_cnt_q[IDX_W-1:0];
          end else begin
            d1_q <= chi_res;
            t1_q <= in_cnt_q[IDX_W-1:0];
          end
        end
        2'b01: begin
          d0_q <= d1_q;
          t0_q <= t1_q;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            d0_q <= chi_res;
            t0_q <= in_cnt_q[IDX_W-1:0];
          end else begin
            d0_q <= d1_q;
            t0_q <= t1_q;
            d1_q <= chi_res;
            t1_q <= in_cnt_q[IDX_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign strm.in_ready    = in_ready_q;
  assign strm.out_valid   = (occ_q != 2'd0);
  assign strm.out_slice   = d0_q;
  assign strm.slice_index = t0_q;
`else
  logic             ov_q;
  logic [24:0]      os_q;
  logic [IDX_W-1:0] oi_q;

  assign strm.in_ready = (state_q == RUN) && (in_cnt_q < CNT_FULL) &&
                         (!ov_q || strm.out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov_q <= 1'b0;
      os_q <= '0;
      oi_q <= '0;
    end else begin
      if (in_fire) begin
        ov_q <= 1'b1;
        os_q <= chi_res;
        oi_q <= in_cnt_q[IDX_W-1:0];
      end else if (out_fire) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign strm.out_valid   = ov_q;
  assign strm.out_slice   = os_q;
  assign strm.slice_index = oi_q;
`endif

endmodule

// File: tb/tb_revaluate_stream.sv
// Testbench for revaluate_stream: table of hand-computed chi vectors cycled
// over full 64-slice runs, plus directed reset, stall, start-poke and
// mid-run reset sequences.
module tb_revaluate_stream;

  typedef struct {
    logic [24:0] din;
    logic [24:0] dexp;
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic finish;

  int checks = 0;
  int errors = 0;

  vec_t tbl[10];

  revaluate_stream_if #(.IDX_W(6)) bus ();

  revaluate_stream #(
    .SLICES(64),
    .IDX_W (6)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .finish(finish),
    .strm  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [24:0] din_of(input bit zero, input int i);
    if (i >= 64) return 25'h1555555;
    if (zero) return 25'h0;
    return tbl[i % 10].din;
  endfunction

  function automatic logic [24:0] exp_of(input bit zero, input int i);
    if (zero) return 25'h0;
    return tbl[i % 10].dexp;
  endfunction

  // One start-to-finish run. Entered and left just after a rising edge.
  task automatic run_state(input bit zero, input int stall_at, input bit toggle,
                           input int rst_after, input bit start_pokes);
    int   icount = 0;
    int   ocount = 0;
    int   cyc = 0;
    int   stall_left = 0;
    int   fin_cnt = 0;
    int   last_hs_cyc = -10;
    int   post = 0;
    bit   stalled = 0;
    bit   prev_hold = 0;
    bit   in_hs;
    logic r0;
    logic [24:0] prev_slice = '0;
    logic [5:0]  prev_idx = '0;

    bus.in_valid  = 1'b1;
    bus.in_slice  = din_of(zero, 0);
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 600) begin
        chk("timeout", cyc, 600);
        break;
      end
`ifdef REVALUATE_SKID_EN
      if (toggle) begin
        r0 = bus.in_ready;
        bus.out_ready = !bus.out_ready;
        #1;
        chk("in_ready_vs_out_ready", bus.in_ready, r0);
        bus.out_ready = !bus.out_ready;
        #1;
      end
`endif
      if (prev_hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_slice", bus.out_slice, prev_slice);
        chk("hold_index", bus.slice_index, prev_idx);
      end
      prev_hold  = bus.out_valid && !bus.out_ready;
      prev_slice = bus.out_slice;
      prev_idx   = bus.slice_index;

      if (finish) begin
        fin_cnt++;
        chk("finish_timing", cyc, last_hs_cyc + 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (ocount >= 64) begin
          chk("extra_output", ocount + 1, 64);
        end else begin
          chk("out_slice", bus.out_slice, exp_of(zero, ocount));
          chk("slice_index", bus.slice_index, ocount);
        end
        ocount++;
        last_hs_cyc = cyc;
      end
      in_hs = bus.in_valid && bus.in_ready;
      if (in_hs) begin
        if (icount >= 64) chk("extra_input", icount + 1, 64);
        icount++;
      end
      if (stall_left > 0 && stall_left <= 6 && icount < 64)
        chk("in_ready_stall", bus.in_ready, 0);

      if (ocount >= 64 && fin_cnt > 0) post++;
      if (post >= 4) break;

      @(posedge clk); #1;
      if (rst_after > 0 && icount == rst_after) begin
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_slice", bus.out_slice, 0);
        chk("rst_slice_index", bus.slice_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_finish", finish, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      start = 1'b0;
      if (start_pokes && (cyc == 20 || (ocount == 64 && last_hs_cyc == cyc)))
        start = 1'b1;
      if (stall_left > 0) stall_left--;
      if (stall_at >= 0 && !stalled && ocount == stall_at) begin
        stalled    = 1;
        stall_left = 10;
      end
      bus.out_ready = (stall_left == 0) && (!toggle || cyc[0]);
      if (in_hs) bus.in_slice = din_of(zero, icount);
    end

    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("in_count", icount, 64);
    chk("out_count", ocount, 64);
    chk("finish_count", fin_cnt, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    tbl[0] = '{25'h0000000, 25'h0000000};
    tbl[1] = '{25'h0000001, 25'h0000009};
    tbl[2] = '{25'h0000002, 25'h0000012};
    tbl[3] = '{25'h1FFFFFF, 25'h1FFFFFF};
    tbl[4] = '{25'h0000020, 25'h0000120};
    tbl[5] = '{25'h0000004, 25'h0000005};
    tbl[6] = '{25'h1000000, 25'h1400000};
    tbl[7] = '{25'h0000003, 25'h000000B};
    tbl[8] = '{25'h000001F, 25'h000001F};
    tbl[9] = '{25'h0000018, 25'h000001A};

    rst = 1'b0;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_slice  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_slice", bus.out_slice, 0);
    chk("reset_slice_index", bus.slice_index, 0);
    chk("reset_busy", busy, 0);
    chk("reset_finish", finish, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // all-zero state, out_ready high
    run_state(1, -1, 0, 0, 0);
    // table data, 10-cycle stall at output 20, start pokes in RUN and DONE
    run_state(0, 20, 0, 0, 1);
    // reset after 30 accepted slices, then a fresh state from index 0
    run_state(0, -1, 0, 30, 0);
    run_state(0, -1, 0, 0, 0);
    // out_ready toggled every cycle
    run_state(0, -1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
